// File: rtl/cpu_pkg.sv
// Shared CPU constants: register index width, operand width, source count and
// the 8080 register-file index map used by decoder, operand fetch and execute.
package cpu_pkg;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NSRC = 4;

    localparam logic [AW-1:0] REG_B   = 4'd0;
    localparam logic [AW-1:0] REG_C   = 4'd1;
    localparam logic [AW-1:0] REG_D   = 4'd2;
    localparam logic [AW-1:0] REG_E   = 4'd3;
    localparam logic [AW-1:0] REG_H   = 4'd4;
    localparam logic [AW-1:0] REG_L   = 4'd5;
    localparam logic [AW-1:0] REG_M   = 4'd6;
    localparam logic [AW-1:0] REG_A   = 4'd7;
    localparam logic [AW-1:0] REG_SP  = 4'd8;
    localparam logic [AW-1:0] REG_PSW = 4'd9;

endpackage

// File: rtl/of_bypass.sv
// Write-bus forwarding for one operand: a register-file write landing on the
// same edge is not yet visible on rdata, so it is taken from the snoop bus.
module of_bypass #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic          wen,
    input  logic [AW-1:0] waddr0,
    input  logic [DW-1:0] wdata0,
    input  logic [AW-1:0] waddr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] fwd
);

    // Port 1 is checked first: it wins when both ports hit the same register.
    always_comb begin
        fwd = d;
        if (wen && (waddr1 == a))
            fwd = wdata1;
        else if (wen && (waddr0 == a))
            fwd = wdata0;
    end

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch: F1 holds a uop while the register-file read is in
// flight, F2 holds forwarded operands for execute; valid/ready on both sides.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int UOP_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [4*AW-1:0]    dec_src,
    input  logic [UOP_W-1:0]   dec_uop,
    output logic [AW-1:0]      raddr0_,
    output logic [AW-1:0]      raddr1_,
    output logic [AW-1:0]      raddr2_,
    output logic [AW-1:0]      raddr3_,
    input  logic [DW-1:0]      rdata0,
    input  logic [DW-1:0]      rdata1,
    input  logic [DW-1:0]      rdata2,
    input  logic [DW-1:0]      rdata3,
    input  logic               wen,
    input  logic [AW-1:0]      waddr0,
    input  logic [DW-1:0]      wdata0,
    input  logic [AW-1:0]      waddr1,
    input  logic [DW-1:0]      wdata1,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [4*DW-1:0]    ex_ops,
    output logic [UOP_W-1:0]   ex_uop
);

    logic               f1_valid, f2_valid;
    logic               adv1, adv2, accept;
    logic [AW-1:0]      src_in  [NSRC];
    logic [AW-1:0]      raddr   [NSRC];
    logic [DW-1:0]      rdata   [NSRC];
    logic [AW-1:0]      f1_src  [NSRC];
    logic [AW-1:0]      f2_src  [NSRC];
    logic [DW-1:0]      op      [NSRC];
    logic [DW-1:0]      cap_op  [NSRC];
    logic [DW-1:0]      hold_op [NSRC];
    logic [UOP_W-1:0]   f1_uop, f2_uop;

    // rst_n gates acceptance so the read addresses read as zero during reset.
    always_comb begin
        adv2      = f2_valid & ex_ready;
        adv1      = f1_valid & (~f2_valid | ex_ready);
        dec_ready = rst_n & ~flush & (~f1_valid | adv1);
        accept    = dec_valid & dec_ready;
    end

    assign rdata[0] = rdata0;
    assign rdata[1] = rdata1;
    assign rdata[2] = rdata2;
    assign rdata[3] = rdata3;

    always_comb begin
        for (int unsigned k = 0; k < NSRC; k++) begin
            src_in[k] = dec_src[k*AW +: AW];
            raddr[k]  = accept ? src_in[k] : f1_src[k];
            ex_ops[k*DW +: DW] = op[k];
        end
    end

    assign raddr0_  = raddr[0];
    assign raddr1_  = raddr[1];
    assign raddr2_  = raddr[2];
    assign raddr3_  = raddr[3];
    assign ex_valid = f2_valid;
    assign ex_uop   = f2_uop;

    for (genvar k = 0; k < NSRC; k++) begin : g_fwd
        of_bypass #(.AW(AW), .DW(DW)) u_cap (
            .a(f1_src[k]), .d(rdata[k]), .wen(wen),
            .waddr0(waddr0), .wdata0(wdata0), .waddr1(waddr1), .wdata1(wdata1),
            .fwd(cap_op[k])
        );
        of_bypass #(.AW(AW), .DW(DW)) u_hold (
            .a(f2_src[k]), .d(op[k]), .wen(wen),
            .waddr0(waddr0), .wdata0(wdata0), .waddr1(waddr1), .wdata1(wdata1),
            .fwd(hold_op[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1_valid <= 1'b0;
            f1_uop   <= '0;
            f1_src   <= '{default: '0};
        end else begin
            if (flush)
                f1_valid <= 1'b0;
            else if (accept)
                f1_valid <= 1'b1;
            else if (adv1)
                f1_valid <= 1'b0;
            if (accept) begin
                f1_uop <= dec_uop;
                f1_src <= src_in;
            end
        end
    end

    // Stalled operands are refreshed from the write bus so they never go stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f2_valid <= 1'b0;
            f2_uop   <= '0;
            f2_src   <= '{default: '0};
            op       <= '{default: '0};
        end else begin
            if (flush)
                f2_valid <= 1'b0;
            else if (adv1)
                f2_valid <= 1'b1;
            else if (adv2)
                f2_valid <= 1'b0;
            if (adv1) begin
                f2_uop <= f1_uop;
                f2_src <= f1_src;
                op     <= cap_op;
            end else if (f2_valid && !ex_ready) begin
                op     <= hold_op;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file
// (address registered on posedge, data read combinationally).
module tb_operand_fetch;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int UOP_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             dec_valid = 1'b0;
    logic             dec_ready;
    logic [4*AW-1:0]  dec_src = '0;
    logic [UOP_W-1:0] dec_uop = '0;
    logic [AW-1:0]    raddr0_, raddr1_, raddr2_, raddr3_;
    logic [DW-1:0]    rdata0, rdata1, rdata2, rdata3;
    logic             wen = 1'b0;
    logic [AW-1:0]    waddr0 = '0, waddr1 = '0;
    logic [DW-1:0]    wdata0 = '0, wdata1 = '0;
    logic             ex_valid;
    logic             ex_ready = 1'b1;
    logic [4*DW-1:0]  ex_ops;
    logic [UOP_W-1:0] ex_uop;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] rf [16];
    logic [AW-1:0] ra_q [4];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ra_q[0] <= raddr0_;
        ra_q[1] <= raddr1_;
        ra_q[2] <= raddr2_;
        ra_q[3] <= raddr3_;
        if (wen) begin
            rf[waddr0] <= wdata0;
            rf[waddr1] <= wdata1;
        end
    end

    assign rdata0 = rf[ra_q[0]];
    assign rdata1 = rf[ra_q[1]];
    assign rdata2 = rf[ra_q[2]];
    assign rdata3 = rf[ra_q[3]];

    operand_fetch #(.AW(AW), .DW(DW), .UOP_W(UOP_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_src(dec_src), .dec_uop(dec_uop),
        .raddr0_(raddr0_), .raddr1_(raddr1_), .raddr2_(raddr2_), .raddr3_(raddr3_),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .wen(wen), .waddr0(waddr0), .wdata0(wdata0), .waddr1(waddr1), .wdata1(wdata1),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ops(ex_ops), .ex_uop(ex_uop)
    );

    function automatic logic [15:0] src_word(input int n);
        return {4'(n + 3), 4'(n + 2), 4'(n + 1), 4'(n)};
    endfunction

    function automatic logic [63:0] ops_of(input logic [15:0] s);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = rf[s[k*4 +: 4]];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload();
        dec_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1;
            waddr0 = 4'(2*i);     wdata0 = 16'(16'h1100 * (2*i));
            waddr1 = 4'(2*i + 1); wdata1 = 16'(16'h1100 * (2*i + 1));
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic test_reset();
        dec_valid = 1'b1;
        dec_src = 16'hFEDC;
        tick();
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        checks++;
        if ({raddr3_, raddr2_, raddr1_, raddr0_} !== 16'h0000) begin
            errors++; $display("FAIL reset_raddr: got %h want 0000", {raddr3_, raddr2_, raddr1_, raddr0_});
        end
        checks++;
        if ({ex_ops, ex_uop} !== 80'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0", ex_ops, ex_uop); end
        dec_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
    endtask

    task automatic test_streaming();
        logic [63:0] exp;
        ex_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dec_valid = (i < 4);
            dec_src = src_word(i);
            dec_uop = 16'(16'hC000 + i);
            #1;
            if (i < 4) begin
                checks++;
                if (dec_ready !== 1'b1) begin errors++; $display("FAIL stream_dec_ready[%0d]: got %b want 1", i, dec_ready); end
            end
            tick();
            if (i >= 1 && i <= 4) begin
                for (int k = 0; k < 4; k++) exp[k*16 +: 16] = 16'(16'h1100 * ((i - 1 + k) % 16));
                checks++;
                if (ex_valid !== 1'b1 || ex_uop !== 16'(16'hC000 + i - 1) || ex_ops !== exp) begin
                    errors++;
                    $display("FAIL stream_uop[%0d]: got v=%b uop=%h ops=%h want v=1 uop=%h ops=%h",
                             i - 1, ex_valid, ex_uop, ex_ops, 16'(16'hC000 + i - 1), exp);
                end
            end else begin
                checks++;
                if (ex_valid !== 1'b0) begin errors++; $display("FAIL stream_idle[%0d]: got %b want 0", i, ex_valid); end
            end
        end
        dec_valid = 1'b0;
    endtask

    task automatic test_bypass();
        logic [15:0] wa1 [2];
        logic [15:0] want [2];
        wa1[0] = 16'h000A; want[0] = 16'hBEEF;
        wa1[1] = 16'h0003; want[1] = 16'h1234;
        ex_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            dec_valid = 1'b1;
            dec_src = 16'h0003;
            dec_uop = 16'(16'hB001 + r);
            tick();
            dec_valid = 1'b0;
            wen = 1'b1;
            waddr0 = 4'd3; wdata0 = 16'hBEEF;
            waddr1 = wa1[r][3:0]; wdata1 = (r == 0) ? 16'h7777 : 16'h1234;
            tick();
            wen = 1'b0;
            checks++;
            if (ex_valid !== 1'b1 || ex_uop !== 16'(16'hB001 + r) || ex_ops !== {48'h0, want[r]}) begin
                errors++;
                $display("FAIL bypass[%0d]: got v=%b uop=%h ops=%h want v=1 uop=%h ops=%h",
                         r, ex_valid, ex_uop, ex_ops, 16'(16'hB001 + r), {48'h0, want[r]});
            end
            tick();
        end
    endtask

    task automatic test_stall_refresh();
        ex_ready = 1'b0;
        dec_valid = 1'b1;
        dec_src = 16'h0050; dec_uop = 16'hA001;
        tick();
        dec_src = 16'h1234; dec_uop = 16'hA002;
        tick();
        dec_src = 16'h9876; dec_uop = 16'hA003;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (dec_ready !== 1'b0 || {raddr3_, raddr2_, raddr1_, raddr0_} !== 16'h1234
                || ex_valid !== 1'b1 || ex_uop !== 16'hA001) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rdy=%b raddr=%h v=%b uop=%h want rdy=0 raddr=1234 v=1 uop=a001",
                         c, dec_ready, {raddr3_, raddr2_, raddr1_, raddr0_}, ex_valid, ex_uop);
            end
            if (c == 1) begin
                checks++;
                if (ex_ops[31:16] !== 16'h5500) begin errors++; $display("FAIL stall_op_before: got %h want 5500", ex_ops[31:16]); end
            end
            if (c == 3) begin
                wen = 1'b1;
                waddr0 = 4'd5; wdata0 = 16'hA5A5;
                waddr1 = 4'd5; wdata1 = 16'hA5A5;
            end
            tick();
            wen = 1'b0;
        end
        checks++;
        if (ex_ops[31:16] !== 16'hA5A5) begin errors++; $display("FAIL stall_refresh: got %h want a5a5", ex_ops[31:16]); end
        ex_ready = 1'b1;
        #1;
        checks++;
        if (dec_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy: got %b want 1", dec_ready); end
        tick();
        dec_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1 || ex_uop !== 16'hA002 || ex_ops !== 64'h1100_2200_1234_4400) begin
            errors++; $display("FAIL stall_next_b: got v=%b uop=%h ops=%h want v=1 uop=a002 ops=1100220012344400", ex_valid, ex_uop, ex_ops);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_uop !== 16'hA003 || ex_ops !== 64'h9900_8800_7700_6600) begin
            errors++; $display("FAIL stall_next_c: got v=%b uop=%h ops=%h want v=1 uop=a003 ops=9900880077006600", ex_valid, ex_uop, ex_ops);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", ex_valid); end
    endtask

    task automatic test_backpressure();
        logic [79:0] q [$];
        logic [79:0] head;
        int sent = 0;
        int got = 0;
        logic exp_rdy;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            ex_ready = (cyc % 2 == 0);
            dec_valid = (sent < 8);
            dec_src = src_word(sent + 4);
            dec_uop = 16'(16'hD000 + sent);
            #1;
            exp_rdy = !((sent - got) == 2 && !ex_ready);
            checks++;
            if (dec_ready !== exp_rdy) begin errors++; $display("FAIL bp_dec_ready[%0d]: got %b want %b", cyc, dec_ready, exp_rdy); end
            if (ex_valid && ex_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_uop: got uop=%h want none", ex_uop);
                end else begin
                    head = q.pop_front();
                    if ({ex_uop, ex_ops} !== head) begin
                        errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, {ex_uop, ex_ops}, head);
                    end
                end
                got++;
            end
            if (dec_valid && dec_ready) begin
                q.push_back({dec_uop, ops_of(dec_src)});
                sent++;
            end
            tick();
        end
        dec_valid = 1'b0;
        checks++;
        if (sent != 8 || got != 8 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL bp_count: got sent=%0d delivered=%0d v=%b want 8 8 0", sent, got, ex_valid);
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        dec_valid = 1'b1;
        dec_src = 16'h0000; dec_uop = 16'hE001;
        tick();
        dec_uop = 16'hE002;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_uop !== 16'hE001) begin errors++; $display("FAIL flush_full: got v=%b uop=%h want v=1 uop=e001", ex_valid, ex_uop); end
        flush = 1'b1;
        ex_ready = 1'b1;
        dec_src = src_word(1); dec_uop = 16'hE003;
        #1;
        checks++;
        if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_dec_ready: got %b want 0", dec_ready); end
        tick();
        flush = 1'b0;
        dec_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ex_valid: got %b want 0", ex_valid); end
        dec_valid = 1'b1;
        dec_src = src_word(2); dec_uop = 16'hE004;
        tick();
        dec_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_latency1: got %b want 0", ex_valid); end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_uop !== 16'hE004 || ex_ops !== ops_of(src_word(2))) begin
            errors++; $display("FAIL flush_next_uop: got v=%b uop=%h ops=%h want v=1 uop=e004 ops=%h",
                               ex_valid, ex_uop, ex_ops, ops_of(src_word(2)));
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak: got v=%b uop=%h want v=0", ex_valid, ex_uop); end
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0;
        dec_valid = 1'b1;
        dec_src = src_word(5); dec_uop = 16'hF001;
        tick();
        dec_src = src_word(7); dec_uop = 16'hF002;
        tick();
        dec_src = src_word(9); dec_uop = 16'hF003;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_uop !== 16'h0000) begin errors++; $display("FAIL areset_ex: got v=%b uop=%h want 0/0000", ex_valid, ex_uop); end
        checks++;
        if ({raddr3_, raddr2_, raddr1_, raddr0_} !== 16'h0000) begin
            errors++; $display("FAIL areset_raddr: got %h want 0000", {raddr3_, raddr2_, raddr1_, raddr0_});
        end
        dec_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (dec_ready !== 1'b1) begin errors++; $display("FAIL areset_release_rdy: got %b want 1", dec_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ex_valid !== 1'b0) begin errors++; $display("FAIL areset_stale[%0d]: got v=%b uop=%h want v=0", c, ex_valid, ex_uop); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload();
        test_streaming();
        test_bypass();
        test_stall_refresh();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
